btb_upd_ctrl: RTL and testbench

- Update controller between branch commit and the BTB training port.
- Accepts up to SIMBRCOM committed branch updates per cycle and buffers them in an in-order queue.
- Drains the queue to the BTB's single update port at one update per cycle.
- Also runs a flush sequencer that walks every BTB index issuing invalidates, e.g. on context switch or BTB reconfiguration; queued updates are discarded on flush.

---
 rtl/btb_upd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_btb_upd_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_upd_ctrl.sv
// BTB update controller: in-order queue of committed branch updates drained one per cycle,
// plus a flush sequencer that invalidates every BTB index. Optional macro: BTB_UPD_CTRL_NT_FILTER_EN.
module btb_upd_ctrl #(
  parameter  int ADDR     = 32,
  parameter  int BTB_D    = 32,
  parameter  int SIMBRCOM = 2,
  parameter  int QDEPTH   = 8,
  localparam int IDX      = $clog2(BTB_D)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SIMBRCOM-1:0]      pc_chg_com_,
  input  logic [SIMBRCOM-1:0]      chg_taken_,
  input  logic [SIMBRCOM*ADDR-1:0] com_addr,
  input  logic [SIMBRCOM*ADDR-1:0] com_tar_addr,
  output logic                     com_ready,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic [ADDR-1:0]          upd_addr,
  output logic [ADDR-1:0]          upd_tar_addr,
  output logic                     inv_valid,
  output logic [IDX-1:0]           inv_idx
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic [IDX-1:0]  inv_idx_q;
  logic            flush_done_q;

  logic [ADDR-1:0] addr_mem  [QDEPTH];
  logic [ADDR-1:0] tar_mem   [QDEPTH];
  logic            taken_mem [QDEPTH];

  logic [SIMBRCOM-1:0] keep;
  logic [PW-1:0]       slot [SIMBRCOM];
  logic [CW-1:0]       enq_n;
  logic                enq_acc;
  logic                deq;

`ifdef BTB_UPD_CTRL_NT_FILTER_EN
  logic [ADDR-1:0] last_pc_q, last_pc_d;
  logic            filt;
`endif

  assign com_ready = (state_q == IDLE) && (count_q <= CW'(QDEPTH - SIMBRCOM));
  assign enq_acc   = com_ready && !flush_req;
  assign deq       = (state_q == IDLE) && (count_q != '0);

  // Compact kept lanes into consecutive slots starting at the tail.
  always_comb begin
    enq_n = '0;
`ifdef BTB_UPD_CTRL_NT_FILTER_EN
    last_pc_d = last_pc_q;
`endif
    for (int n = 0; n < SIMBRCOM; n++) begin
      keep[n] = !pc_chg_com_[n];
`ifdef BTB_UPD_CTRL_NT_FILTER_EN
      // Not-taken repeats of the newest entry or of an earlier lane add no information.
      filt = (count_q != '0) && (com_addr[n*ADDR +: ADDR] == last_pc_q);
      for (int m = 0; m < n; m++) begin
        if (!pc_chg_com_[m] && (com_addr[m*ADDR +: ADDR] == com_addr[n*ADDR +: ADDR]))
          filt = 1'b1;
      end
      if (chg_taken_[n] && filt)
        keep[n] = 1'b0;
      if (keep[n])
        last_pc_d = com_addr[n*ADDR +: ADDR];
`endif
      slot[n] = tail_q + enq_n[PW-1:0];
      if (keep[n])
        enq_n = enq_n + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (enq_acc)
      count_d = count_d + enq_n;
    if (deq)
      count_d = count_d - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      inv_idx_q    <= '0;
      flush_done_q <= 1'b0;
`ifdef BTB_UPD_CTRL_NT_FILTER_EN
      last_pc_q    <= '0;
`endif
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q   <= FLUSH;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            inv_idx_q <= '0;
          end else begin
            if (deq)
              head_q <= head_q + 1'b1;
            if (enq_acc) begin
              tail_q <= tail_q + enq_n[PW-1:0];
`ifdef BTB_UPD_CTRL_NT_FILTER_EN
              last_pc_q <= last_pc_d;
`endif
            end
            count_q <= count_d;
          end
        end
        FLUSH: begin
          if (flush_req) begin
            inv_idx_q <= '0;
          end else if (inv_idx_q == IDX'(BTB_D - 1)) begin
            state_q      <= IDLE;
            inv_idx_q    <= '0;
            flush_done_q <= 1'b1;
          end else begin
            inv_idx_q <= inv_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    for (int n = 0; n < SIMBRCOM; n++) begin
      if (enq_acc && keep[n]) begin
        addr_mem[slot[n]]  <= com_addr[n*ADDR +: ADDR];
        tar_mem[slot[n]]   <= com_tar_addr[n*ADDR +: ADDR];
        taken_mem[slot[n]] <= !chg_taken_[n];
      end
    end
  end

  assign upd_valid    = deq;
  assign upd_taken    = taken_mem[head_q];
  assign upd_addr     = addr_mem[head_q];
  assign upd_tar_addr = tar_mem[head_q];
  assign inv_valid    = (state_q == FLUSH);
  assign flush_busy   = (state_q == FLUSH);
  assign inv_idx      = inv_idx_q;
  assign flush_done   = flush_done_q;

endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Scoreboard bench for btb_upd_ctrl: a queue/flush model predicts every output each cycle.
module tb_btb_upd_ctrl;

  localparam int ADDR = 32;
  localparam int BTB_D = 32;
  localparam int NL = 2;
  localparam int QD = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NL-1:0]   pc_chg_com_, chg_taken_;
  logic [NL*ADDR-1:0] com_addr, com_tar_addr;
  logic            com_ready, flush_req, flush_busy, flush_done;
  logic            upd_valid, upd_taken, inv_valid;
  logic [ADDR-1:0] upd_addr, upd_tar_addr;
  logic [4:0]      inv_idx;

  btb_upd_ctrl #(.ADDR(ADDR), .BTB_D(BTB_D), .SIMBRCOM(NL), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset), .pc_chg_com_(pc_chg_com_), .chg_taken_(chg_taken_),
    .com_addr(com_addr), .com_tar_addr(com_tar_addr), .com_ready(com_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_addr(upd_addr),
    .upd_tar_addr(upd_tar_addr), .inv_valid(inv_valid), .inv_idx(inv_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] addr;
    logic [31:0] tar;
  } upd_t;

  upd_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  bit          flushing = 0;
  bit          done_pend = 0;
  int          exp_idx = 0;
  logic [31:0] last_pc = '0;
  int          upd_seen = 0;
  bit          saw_not_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    pc_chg_com_  = '1;
    chg_taken_   = '1;
    com_addr     = '0;
    com_tar_addr = '0;
    flush_req    = 1'b0;
  endtask

  task automatic lane(input int n, input logic taken, input logic [31:0] a, input logic [31:0] t);
    pc_chg_com_[n]             = 1'b0;
    chg_taken_[n]              = !taken;
    com_addr[n*ADDR +: ADDR]     = a;
    com_tar_addr[n*ADDR +: ADDR] = t;
  endtask

  // One clock: check outputs against the model, advance the model, then cross the edge.
  task automatic tick();
    bit   ready_exp, had, filt;
    upd_t e;
    @(negedge clk);
    if (flushing) begin
      chk("flush_inv_valid", 64'(inv_valid), 64'd1);
      chk("flush_busy", 64'(flush_busy), 64'd1);
      chk("flush_inv_idx", 64'(inv_idx), 64'(exp_idx));
      chk("flush_upd_valid", 64'(upd_valid), 64'd0);
      chk("flush_com_ready", 64'(com_ready), 64'd0);
      chk("flush_done_early", 64'(flush_done), 64'd0);
      if (flush_req) exp_idx = 0;
      else if (exp_idx == BTB_D - 1) begin flushing = 0; done_pend = 1; end
      else exp_idx++;
    end else begin
      ready_exp = (QD - sb.size()) >= NL;
      had = sb.size() > 0;
      chk("idle_inv_valid", 64'(inv_valid), 64'd0);
      chk("idle_busy", 64'(flush_busy), 64'd0);
      chk("flush_done", 64'(flush_done), 64'(done_pend));
      done_pend = 0;
      chk("com_ready", 64'(com_ready), 64'(ready_exp));
      if (com_ready === 1'b0) saw_not_ready = 1;
      chk("upd_valid", 64'(upd_valid), 64'(had));
      if (upd_valid === 1'b1) upd_seen++;
      if (had) begin
        e = sb.pop_front();
        chk("upd_taken", 64'(upd_taken), 64'(e.taken));
        chk("upd_addr", 64'(upd_addr), 64'(e.addr));
        chk("upd_tar_addr", 64'(upd_tar_addr), 64'(e.tar));
        $display("[TB] update pc=%h tgt=%h taken=%0d", e.addr, e.tar, e.taken);
      end
      if (flush_req) begin
        sb.delete();
        flushing = 1;
        exp_idx = 0;
      end else if (ready_exp) begin
        for (int n = 0; n < NL; n++) begin
          if (!pc_chg_com_[n]) begin
            filt = 0;
`ifdef BTB_UPD_CTRL_NT_FILTER_EN
            if (chg_taken_[n]) begin
              if (had && com_addr[n*ADDR +: ADDR] == last_pc) filt = 1;
              for (int m = 0; m < n; m++)
                if (!pc_chg_com_[m] && com_addr[m*ADDR +: ADDR] == com_addr[n*ADDR +: ADDR])
                  filt = 1;
            end
`endif
            if (!filt) begin
              sb.push_back('{taken: !chg_taken_[n], addr: com_addr[n*ADDR +: ADDR],
                             tar: com_tar_addr[n*ADDR +: ADDR]});
              last_pc = com_addr[n*ADDR +: ADDR];
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_upd_valid"}, 64'(upd_valid), 64'd0);
    chk({tag, "_inv_valid"}, 64'(inv_valid), 64'd0);
    chk({tag, "_inv_idx"}, 64'(inv_idx), 64'd0);
    chk({tag, "_flush_busy"}, 64'(flush_busy), 64'd0);
    chk({tag, "_flush_done"}, 64'(flush_done), 64'd0);
    chk({tag, "_com_ready"}, 64'(com_ready), 64'd1);
  endtask

  task automatic clear_model();
    sb.delete();
    flushing = 0;
    done_pend = 0;
    exp_idx = 0;
  endtask

  int base;

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Single taken commit on lane 0, visible one cycle later, then gone.
    lane(0, 1'b1, 32'hdeadbe74, 32'hcafecafe);
    tick();
    idle_in();
    repeat (3) tick();

    // Lane 1 alone is compacted into a single entry.
    lane(1, 1'b1, 32'h100, 32'h180);
    tick();
    idle_in();
    repeat (3) tick();

    // Both lanes for 4 cycles: 8 updates in lane/cycle order.
    base = upd_seen;
    for (int c = 0; c < 4; c++) begin
      lane(0, c[0], 32'h1000 + c * 8, 32'h2000 + c);
      lane(1, !c[0], 32'h1004 + c * 8, 32'h3000 + c);
      tick();
    end
    idle_in();
    repeat (10) tick();
    chk("burst4_count", 64'(upd_seen - base), 64'd8);

    // Sustained both-lane commits until the queue backs up.
    base = upd_seen;
    saw_not_ready = 0;
    for (int c = 0; c < 8; c++) begin
      lane(0, 1'b1, 32'h4000 + c * 8, 32'h5000 + c);
      lane(1, 1'b0, 32'h4004 + c * 8, 32'h6000 + c);
      tick();
    end
    idle_in();
    repeat (12) tick();
    chk("burst8_count", 64'(upd_seen - base), 64'd14);
    chk("burst8_backpressure", 64'(saw_not_ready), 64'd1);

    // Two consecutive not-taken commits to the same PC.
    base = upd_seen;
    lane(0, 1'b0, 32'h200, 32'h240);
    tick();
    tick();
    idle_in();
    repeat (4) tick();
`ifdef BTB_UPD_CTRL_NT_FILTER_EN
    chk("nt_repeat_count", 64'(upd_seen - base), 64'd1);
`else
    chk("nt_repeat_count", 64'(upd_seen - base), 64'd2);
`endif

    // Five queued entries, then a flush with a same-cycle commit that must be dropped.
    for (int c = 0; c < 4; c++) begin
      lane(0, 1'b1, 32'h7000 + c * 8, 32'h7100 + c);
      lane(1, 1'b1, 32'h7004 + c * 8, 32'h7200 + c);
      tick();
    end
    chk("pre_flush_depth", 64'(sb.size()), 64'd5);
    flush_req = 1'b1;
    base = upd_seen;
    tick();
    idle_in();
    repeat (33) tick();
    chk("flush_done_seen_idle", 64'(flushing), 64'd0);
    repeat (4) tick();
    chk("flush_no_updates", 64'(upd_seen - base), 64'd1);

    // Restart the walk at index 10; done only after the full restarted walk.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 40 && exp_idx != 10; c++) tick();
    chk("restart_at_idx", 64'(exp_idx), 64'd10);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (32) tick();
    chk("restart_still_busy", 64'(flushing), 64'd0);
    repeat (2) tick();

    // Reset in the middle of a flush.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midflush_reset");
    clear_model();
    reset = 1'b0;
    lane(0, 1'b1, 32'h8000, 32'h8800);
    tick();
    idle_in();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
